// File: rtl/dds_phase_synth.sv
// dds_phase_synth: clamped tuning word, phase accumulator, quarter-wave sine ROM.
// Optional phase dither before truncation: define DDS_PHASE_DITHER_EN.

module dds_phase_synth #(
   parameter int                   ACC_WIDTH  = 32,
   parameter int                   PHASE_BITS = 10,
   parameter int                   OUT_WIDTH  = 8,
   parameter logic [ACC_WIDTH-1:0] STEP_MIN   = 32'd10000,
   parameter logic [ACC_WIDTH-1:0] STEP_MAX   = 32'd2000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ACC_WIDTH-1:0] step_in,
   input  logic                 enable,
   output logic [OUT_WIDTH-1:0] wave_out,
   output logic                 sample_valid,
   output logic                 sync_out,
   output logic [ACC_WIDTH-1:0] phase_out
);

   localparam int AW        = PHASE_BITS - 2;
   localparam int ROM_DEPTH = 1 << AW;
   localparam logic [OUT_WIDTH-1:0] MID = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Quarter-wave entry, sampled at bin centres; evaluated at elaboration only.
   function automatic logic [OUT_WIDTH-2:0] rom_entry(input int i);
      real x;
      real term;
      real s;
      int  v;
      x    = 3.14159265358979323846 / 2.0 * ($itor(i) + 0.5) / $itor(ROM_DEPTH);
      term = x;
      s    = x;
      for (int k = 1; k < 14; k++) begin
         term = -term * x * x / $itor((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      v = $rtoi($itor((1 << (OUT_WIDTH - 1)) - 1) * s + 0.5);
      return v[OUT_WIDTH-2:0];
   endfunction

   logic [OUT_WIDTH-2:0] rom [ROM_DEPTH];

   for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
      assign rom[g] = rom_entry(g);
   end

   logic [ACC_WIDTH-1:0]  step_q;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH:0]    sum;
   logic                  v1, w1;
   logic [PHASE_BITS-1:0] p;
   logic [AW-1:0]         addr_d;
   logic [AW-1:0]         addr;
   logic                  half2, v2, w2;
   logic [OUT_WIDTH-2:0]  q;
   logic                  half3, v3, w3;

   // Carry-extended accumulator sum; the top bit is the wrap flag.
   always_comb sum = {1'b0, acc} + {1'b0, step_q};

   // S0: clamp the tuning word into the legal range every cycle.
   always_ff @(posedge clk) begin
      if (reset)
         step_q <= STEP_MIN;
      else if (step_in < STEP_MIN)
         step_q <= STEP_MIN;
      else if (step_in > STEP_MAX)
         step_q <= STEP_MAX;
      else
         step_q <= step_in;
   end

   // S1: integrate the step on enabled cycles and flag the carry.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         v1  <= 1'b0;
         w1  <= 1'b0;
      end else begin
         v1 <= enable;
         w1 <= enable & sum[ACC_WIDTH];
         if (enable)
            acc <= sum[ACC_WIDTH-1:0];
      end
   end

`ifdef DDS_PHASE_DITHER_EN
   localparam logic [ACC_WIDTH-1:0] DMASK = {ACC_WIDTH{1'b1}} >> PHASE_BITS;

   logic [15:0]           lfsr;
   logic [ACC_WIDTH+15:0] lfsr_ext;
   logic [ACC_WIDTH-1:0]  dither;
   logic [ACC_WIDTH-1:0]  dsum;

   // Dither LFSR, x^16+x^14+x^13+x^11+1, steps with the accumulator.
   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (enable)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // Dithered phase: low LFSR bits land only below the truncation point.
   always_comb begin
      lfsr_ext = {{ACC_WIDTH{1'b0}}, lfsr};
      dither   = lfsr_ext[ACC_WIDTH-1:0] & DMASK;
      dsum     = acc + dither;
      p        = dsum[ACC_WIDTH-1 -: PHASE_BITS];
   end
`else
   // Plain truncation of the accumulator.
   always_comb p = acc[ACC_WIDTH-1 -: PHASE_BITS];
`endif

   // Odd quadrants read the quarter table backwards.
   always_comb addr_d = p[PHASE_BITS-2] ? ~p[AW-1:0] : p[AW-1:0];

   // S2: register ROM address and half-wave sign.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr  <= '0;
         half2 <= 1'b0;
         v2    <= 1'b0;
         w2    <= 1'b0;
      end else begin
         addr  <= addr_d;
         half2 <= p[PHASE_BITS-1];
         v2    <= v1;
         w2    <= w1;
      end
   end

   // S3: synchronous ROM read.
   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= '0;
         half3 <= 1'b0;
         v3    <= 1'b0;
         w3    <= 1'b0;
      end else begin
         q     <= rom[addr];
         half3 <= half2;
         v3    <= v2;
         w3    <= w2;
      end
   end

   // S4: offset-binary output, held while no valid sample arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         wave_out     <= MID;
         sample_valid <= 1'b0;
         sync_out     <= 1'b0;
      end else begin
         sample_valid <= v3;
         sync_out     <= v3 & w3;
         if (v3)
            wave_out <= half3 ? MID - {1'b0, q} : MID + {1'b0, q};
      end
   end

   assign phase_out = acc;

endmodule

// File: tb/tb_dds_phase_synth.sv
// tb_dds_phase_synth: random and directed checks of dds_phase_synth
// against a sine/phase reference model, default and widened clamp.

module tb_dds_phase_synth;

   localparam logic [31:0] SMIN = 32'd10000;
   localparam int          NMAX = 20000;
   localparam real         PI   = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] step_in = '0;
   logic [7:0]  wave0, wave1;
   logic        sv0, sv1, sy0, sy1;
   logic [31:0] ph0, ph1;

   dds_phase_synth u_dut (
      .clk          (clk),
      .reset        (reset),
      .step_in      (step_in),
      .enable       (enable),
      .wave_out     (wave0),
      .sample_valid (sv0),
      .sync_out     (sy0),
      .phase_out    (ph0)
   );

   dds_phase_synth #(.STEP_MAX(32'hFFFF_FFFF)) u_wide (
      .clk          (clk),
      .reset        (reset),
      .step_in      (step_in),
      .enable       (enable),
      .wave_out     (wave1),
      .sample_valid (sv1),
      .sync_out     (sy1),
      .phase_out    (ph1)
   );

   always #5 clk = ~clk;

   int  n_tests = 0;
   int  n_fail = 0;
   bit  chk_on = 1'b0;
   int  cyc = 0;
   int  last_rst = 0;

   logic [31:0] m_step [2];
   logic [31:0] m_acc  [2];
   logic [7:0]  m_wave [2];
   logic        m_sv   [2];
   logic        m_sy   [2];
   logic        hv [2][NMAX];
   logic        hw [2][NMAX];
   logic [31:0] ha [2][NMAX];

   function automatic logic [31:0] smax(input int d);
      return (d == 0) ? 32'd2000000 : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] clamp(input logic [31:0] s, input int d);
      if (s < SMIN) return SMIN;
      if (s > smax(d)) return smax(d);
      return s;
   endfunction

   // Ideal sample: quarter index from the top 10 phase bits, 127-scaled sine.
   function automatic logic [7:0] sine_sample(input logic [31:0] a);
      int  p, quad, k, idx, r;
      real v;
      p    = int'(a >> 22);
      quad = p / 256;
      k    = p % 256;
      idx  = (quad % 2 == 1) ? 255 - k : k;
      v    = 127.0 * $sin(PI / 2.0 * ($itor(idx) + 0.5) / 256.0);
      r    = $rtoi(v + 0.5);
      return (quad >= 2) ? 8'(128 - r) : 8'(128 + r);
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One rising edge of the reference: phase history plus 3-edge sample delay.
   task automatic model_edge();
      logic [32:0] s;
      int          src;
      cyc++;
      if (cyc >= NMAX) begin
         $display("FAIL cycle_budget: got %0d, expected < %0d", cyc, NMAX);
         $fatal(1, "cycle budget exhausted");
      end
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_step[d] = SMIN;
            m_acc[d]  = '0;
            hv[d][cyc] = 1'b0;
            hw[d][cyc] = 1'b0;
            ha[d][cyc] = '0;
            m_wave[d] = 8'd128;
            m_sv[d]   = 1'b0;
            m_sy[d]   = 1'b0;
         end else begin
            s = {1'b0, m_acc[d]} + {1'b0, m_step[d]};
            if (enable) m_acc[d] = s[31:0];
            hv[d][cyc] = enable;
            hw[d][cyc] = enable & s[32];
            ha[d][cyc] = m_acc[d];
            m_step[d]  = clamp(step_in, d);
            src = cyc - 3;
            if (src > last_rst && hv[d][src]) begin
               m_wave[d] = sine_sample(ha[d][src]);
               m_sv[d]   = 1'b1;
               m_sy[d]   = hw[d][src];
            end else begin
               m_sv[d] = 1'b0;
               m_sy[d] = 1'b0;
            end
         end
      end
      if (reset) last_rst = cyc;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (chk_on) begin
         check("wave0",  {24'd0, wave0}, {24'd0, m_wave[0]});
         check("valid0", {31'd0, sv0},   {31'd0, m_sv[0]});
         check("sync0",  {31'd0, sy0},   {31'd0, m_sy[0]});
         check("phase0", ph0,            m_acc[0]);
         check("wave1",  {24'd0, wave1}, {24'd0, m_wave[1]});
         check("valid1", {31'd0, sv1},   {31'd0, m_sv[1]});
         check("sync1",  {31'd0, sy1},   {31'd0, m_sy[1]});
         check("phase1", ph1,            m_acc[1]);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_wave"},  {24'd0, wave0}, 32'd128);
      check({tag, "_valid"}, {31'd0, sv0},   32'd0);
      check({tag, "_sync"},  {31'd0, sy0},   32'd0);
      check({tag, "_phase"}, ph0,            32'd0);
      check({tag, "_wave_w"},  {24'd0, wave1}, 32'd128);
      check({tag, "_valid_w"}, {31'd0, sv1},   32'd0);
      check({tag, "_phase_w"}, ph1,            32'd0);
   endtask

   initial begin
      logic [31:0] p0, p1, e, frozen;
      logic [7:0]  held;
      logic [7:0]  pat [4];
      int          prev, npulse, gap;

      pat = '{8'd255, 8'd128, 8'd1, 8'd128};

      reset = 1'b1; enable = 1'b1; step_in = '0;
      tick(); tick();
      check_reset_state("reset");
      chk_on = 1'b1;

      reset = 1'b0; step_in = '0; enable = 1'b1;
      p0 = ph0; p1 = ph1;
      tick();
      check("clamp_lo", ph0 - p0, 32'd10000);
      check("clamp_lo_w", ph1 - p1, 32'd10000);
      step_in = 32'hFFFF_FFFF;
      p0 = ph0; p1 = ph1;
      tick();
      check("clamp_lat", ph0 - p0, 32'd10000);
      check("clamp_lat_w", ph1 - p1, 32'd10000);
      p0 = ph0; p1 = ph1;
      tick();
      check("clamp_hi", ph0 - p0, 32'd2000000);
      check("clamp_hi_w", ph1 - p1, 32'hFFFF_FFFF);

      reset = 1'b1; enable = 1'b0; step_in = 32'h4000_0000;
      tick(); tick();
      reset = 1'b0;
      tick();
      enable = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         e = 32'(c) << 30;
         check("quad_phase", ph1, e);
         if (c >= 4) begin
            check("quad_wave", {24'd0, wave1}, {24'd0, pat[(c-4)%4]});
            check("quad_valid", {31'd0, sv1}, 32'd1);
         end
      end

      step_in = 32'd2000000;
      prev = -1; npulse = 0;
      for (int i = 0; i < 7000 && npulse < 3; i++) begin
         tick();
         if (sy0) begin
            check("sync_valid", {31'd0, sv0}, 32'd1);
            if (prev >= 0) begin
               gap = i - prev;
               check("sync_gap_ok", {31'd0, (gap == 2147 || gap == 2148)}, 32'd1);
            end
            prev = i;
            npulse++;
         end
      end
      check("sync_count", npulse, 32'd3);

      enable = 1'b0;
      frozen = ph0;
      held = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("gate_phase", ph0, frozen);
         check("gate_valid", {31'd0, sv0}, {31'd0, (i < 3)});
         if (i == 2) held = wave0;
         if (i >= 3) check("gate_hold", {24'd0, wave0}, {24'd0, held});
      end
      enable = 1'b1;
      tick();
      check("gate_resume", ph0, frozen + 32'd2000000);

      for (int i = 0; i < 37 + int'($urandom_range(0, 50)); i++) tick();
      reset = 1'b1;
      tick();
      check_reset_state("midrst");
      reset = 1'b0; enable = 1'b0; step_in = 32'd2000000;
      tick();
      enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("rst_valid", {31'd0, sv0}, {31'd0, (k == 4)});
         if (k == 4) begin
            check("rst_first", {24'd0, wave0}, 32'd128);
            check("rst_first_w", {24'd0, wave1}, 32'd128);
         end
      end

      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: step_in = $urandom_range(0, 20000);
            1: step_in = $urandom;
            2: step_in = $urandom_range(10000, 2000000);
            default: ;
         endcase
         enable = ($urandom_range(0, 9) != 0);
         reset  = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
